// File: rtl/ta_adc_pack.sv
`default_nettype none
// ============================================================================
// Module   : ta_adc_pack
// Brief    : Multi-channel, trigger-gated ADC sample packer with decimation.
//            Packs PACK accepted samples per channel into one merge word and
//            emits cap_len words per capture window (single-shot or
//            continuous re-arm).
// Revision : 1.0 - initial release
// ============================================================================
module ta_adc_pack #(
    parameter int ADC_W = 14,
    parameter int CH    = 2,
    parameter int PACK  = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk250,
    input  logic                      rst,
    input  logic [CH*ADC_W-1:0]       adc_data,
    input  logic [CH-1:0]             adc_of,
    input  logic                      adc_vld,
    input  logic                      cap_trig,
    input  logic                      cap_abort,
    input  logic                      cap_mode,
    input  logic [CNT_W-1:0]          cap_len,
    input  logic [7:0]                cap_dec,
    output logic [CH*PACK*ADC_W-1:0]  merge_data,
    output logic                      merge_datv,
    output logic [CH-1:0]             merge_of,
    output logic                      cap_busy,
    output logic                      cap_cmpt,
    output logic                      cap_ovr
);

    localparam int c_IDX_W  = $clog2(PACK);
    localparam int c_WORD_W = CH * PACK * ADC_W;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(PACK - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]          r_state;
    logic                r_trig_d;
    logic [CNT_W-1:0]    r_len;
    logic [7:0]          r_dec;
    logic [7:0]          r_dec_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]    r_wcnt;
    logic [c_WORD_W-1:0] r_pack;
    logic [CH-1:0]       r_of_acc;

    logic                w_trig_edge;
    logic                w_accept;
    logic                w_last;
    logic                w_win_end;
    logic [CNT_W-1:0]    w_wcnt_inc;
    logic [c_WORD_W-1:0] w_pack_nxt;
    logic [CH-1:0]       w_of_nxt;

    assign w_trig_edge = cap_trig & ~r_trig_d;
    assign w_accept    = (r_state == S_RUN) & adc_vld & (r_dec_cnt == 8'd0);
    assign w_last      = w_accept & (r_idx == c_IDX_LAST);
    assign w_wcnt_inc  = r_wcnt + 1'b1;
    assign w_win_end   = w_last & (w_wcnt_inc == r_len);
    assign w_of_nxt    = r_of_acc | adc_of;

    // Pack buffer with the current sample of every channel dropped into slot k.
    always_comb begin
        w_pack_nxt = r_pack;
        for (int c = 0; c < CH; c++) begin
            w_pack_nxt[(c * PACK + int'(r_idx)) * ADC_W +: ADC_W] = adc_data[c * ADC_W +: ADC_W];
        end
    end

    // Capture control FSM, decimation, packing and output registers.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_trig_d   <= 1'b0;
            r_len      <= '0;
            r_dec      <= '0;
            r_dec_cnt  <= '0;
            r_idx      <= '0;
            r_wcnt     <= '0;
            r_pack     <= '0;
            r_of_acc   <= '0;
            merge_data <= '0;
            merge_datv <= 1'b0;
            merge_of   <= '0;
            cap_busy   <= 1'b0;
            cap_cmpt   <= 1'b0;
            cap_ovr    <= 1'b0;
        end else begin
            r_trig_d   <= cap_trig;
            merge_datv <= 1'b0;
            cap_cmpt   <= 1'b0;
            cap_ovr    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_edge) begin
                        if (cap_len != '0) begin
                            r_len     <= cap_len;
                            r_dec     <= cap_dec;
                            r_dec_cnt <= '0;
                            r_idx     <= '0;
                            r_wcnt    <= '0;
                            r_of_acc  <= '0;
                            r_state   <= S_RUN;
                            cap_busy  <= 1'b1;
                        end else begin
                            cap_ovr <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_trig_edge) begin
                        cap_ovr <= 1'b1;
                    end
                    // Abort takes priority over any acceptance on the same edge.
                    if (cap_abort) begin
                        r_state  <= S_IDLE;
                        cap_busy <= 1'b0;
                    end else if (w_accept) begin
                        r_dec_cnt <= r_dec;
                        r_pack    <= w_pack_nxt;
                        r_of_acc  <= w_of_nxt;
                        r_idx     <= r_idx + 1'b1;
                        if (w_last) begin
                            merge_data <= w_pack_nxt;
                            merge_of   <= w_of_nxt;
                            merge_datv <= 1'b1;
                            r_of_acc   <= '0;
                            r_idx      <= '0;
                            r_wcnt     <= w_wcnt_inc;
                            if (w_win_end) begin
                                cap_cmpt <= 1'b1;
                                if (!cap_mode || (cap_len == '0)) begin
                                    r_state  <= S_IDLE;
                                    cap_busy <= 1'b0;
                                end else begin
                                    // Continuous re-arm: fresh window parameters.
                                    r_len     <= cap_len;
                                    r_dec     <= cap_dec;
                                    r_wcnt    <= '0;
                                    r_dec_cnt <= '0;
                                end
                            end
                        end
                    end else if (adc_vld) begin
                        r_dec_cnt <= r_dec_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    cap_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ta_adc_pack.md
# ta_adc_pack

Multi-channel, trigger-gated ADC sample packer in the clk250 domain, the successor to the single-channel merge path. It takes CH deserialised ADC channels and applies an optional decimation. It packs PACK consecutive accepted samples per channel into one wide merge word, and emits a programmed number of words per capture window. Single-shot and continuous (auto re-arm) capture modes are supported. It sits between the ADC deserialisers and the capture memory write port, under control of the capture sync logic.

## Interface
Parameters:
- ADC_W, 14, bits per ADC sample
- CH, 2, number of ADC channels
- PACK, 4, samples per channel per merge word (≥2)
- CNT_W, 16, width of window word counter

Ports:
- clk250  in  1  sample clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- adc_data  in  CH*ADC_W  channel c sample at [c*ADC_W +: ADC_W]
- adc_of  in  CH  per-channel overrange flag, aligned with adc_data
- adc_vld  in  1  adc_data/adc_of valid this cycle
- cap_trig  in  1  capture trigger level; rising edge starts a window
- cap_abort  in  1  synchronous abort
- cap_mode  in  1  0 = single-shot, 1 = continuous
- cap_len  in  CNT_W  merge words per window; latched at start
- cap_dec  in  8  decimation: accept 1 of every cap_dec+1 valid samples; latched at start
- merge_data  out  CH*PACK*ADC_W  packed word
- merge_datv  out  1  merge_data valid strobe
- merge_of  out  CH  per-channel OR of adc_of over the word's samples
- cap_busy  out  1  window in progress
- cap_cmpt  out  1  one-cycle window-complete pulse
- cap_ovr  out  1  one-cycle pulse: trigger edge ignored

## Operation
- Trigger edge: trig_edge = cap_trig & ~cap_trig_d, where cap_trig_d is registered.
- States: IDLE, RUN.
- IDLE, trig_edge, cap_len≠0:
  - latch cap_len and cap_dec; clear dec_cnt, pack index, word count and of accumulators
  - go to RUN
- IDLE, trig_edge, cap_len=0: stay in IDLE; pulse cap_ovr.
- RUN, sample acceptance:
  - a sample is accepted when adc_vld=1 and dec_cnt=0; dec_cnt then reloads the latched cap_dec
  - adc_vld=1 with dec_cnt≠0: dec_cnt decrements
  - adc_vld=0: dec_cnt holds
- Packing:
  - the k-th accepted sample of a word (k=0 oldest) of channel c goes to bits [(c*PACK+k)*ADC_W +: ADC_W]
  - merge_of[c] is the OR of adc_of[c] over the word's PACK samples
- Word emission:
  - on acceptance of sample k=PACK-1, the word is registered to merge_data/merge_of, merge_datv pulses, and word count increments
  - when word count reaches the latched cap_len, that final word's merge_datv coincides with a cap_cmpt pulse
- Window end:
  - cap_mode=0: return to IDLE
  - cap_mode=1: stay in RUN, reset word count/pack index/dec_cnt, re-latch cap_len and cap_dec; the next accepted sample is k=0 of the new window
  - cap_mode is sampled only at window end
  - if cap_len=0 at re-latch time, go to IDLE
- trig_edge in RUN: ignored; pulse cap_ovr.
- cap_abort in RUN:
  - discard the partial word; go to IDLE next edge
  - no merge_datv, no cap_cmpt
  - cap_abort in IDLE has no effect
- cap_abort and final-word acceptance on the same edge: abort wins; no datv, no cmpt.
- merge_data holds its last value between strobes; it is not cleared on window end.

## Timing
- Reset: all outputs 0, state IDLE, cap_trig_d=0; a cap_trig already high at reset release creates an edge on the first clock.
- Trigger edge on edge E: cap_busy=1 from E; the first sample eligible for acceptance is the one presented in the cycle after E.
- Latency: merge_datv is high for exactly one cycle, following the edge that accepts sample PACK-1; maximum strobe rate is 1 per PACK cycles (cap_dec=0, adc_vld=1 continuously).
- cap_busy drops on the same edge that raises the final cap_cmpt (single-shot) or the abort edge; in continuous mode cap_busy stays 1 across windows.
- Word counter: CNT_W bits, no wrap within a window; maximum window is 2^CNT_W-1 words.
- cap_ovr and cap_cmpt are single-cycle pulses; they never stretch.

## Test plan
- CH=2, PACK=4, cap_dec=0, cap_len=3, adc_vld=1, ramp data → 3 strobes, 4 cycles apart; word 0 ch0 = {3,2,1,0} (k=0 in LSBs); cap_cmpt on the 3rd strobe; cap_busy low after.
- cap_dec=2, adc_vld toggling 1/0, cap_len=1 → accepts valid samples #0,#3,#6,#9 only; one strobe; cmpt.
- adc_of[1] high for one accepted sample in word 2 → merge_of=2'b10 on word 2 only.
- cap_mode=1, cap_len=2, 3 windows, then clear cap_mode → 6 strobes, 3 cmpt pulses, cap_busy continuous, then IDLE.
- Trigger edge mid-RUN, and trigger with cap_len=0 → cap_ovr pulse each; no change to window output.
- cap_abort after 2 samples of word 1; abort coincident with final sample; async rst mid-RUN → no strobe/cmpt for the aborted word; all outputs 0 immediately on rst.
